// File: rtl/exhaustive_vector_checker.sv
// Exhaustive self-test sequencer for a combinational block: walks every input
// vector, holds each one for SETTLE cycles, compares DUT against golden output
// on a single sample cycle and accumulates mismatch statistics.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for start; results of the last run (or abort) held
// S_APPLY  | vec_out driven, settle counter running
// S_SAMPLE | one compare cycle, sample_strobe high
// S_DONE   | single sweep finished; results held until next start
module exhaustive_vector_checker #(
   parameter int N_IN   = 4,
   parameter int N_OUT  = 1,
   parameter int SETTLE = 1,
   parameter int ERR_W  = 16,
   parameter int SWP_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             continuous,
   input  logic             abort,
   output logic [N_IN-1:0]  vec_out,
   input  logic [N_OUT-1:0] dut_y,
   input  logic [N_OUT-1:0] exp_y,
   output logic             sample_strobe,
   output logic             busy,
   output logic             done,
   output logic             sweep_done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             first_fail_valid,
   output logic [N_IN-1:0]  first_fail_vec,
   output logic [SWP_W-1:0] sweep_cnt
);

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(SETTLE - 1);
   localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};
   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_APPLY  = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             mode_cont;
   logic [CNT_W-1:0] settle_cnt;

   logic             idle_like;
   logic             start_go;
   logic             settle_tc;
   logic             last_vec;
   logic             mismatch;
   logic             count_err;
   logic [ERR_W-1:0] err_after;

   assign idle_like     = (state == S_IDLE) || (state == S_DONE);
   // abort outranks start even while idle, so a simultaneous pair is a no-op
   assign start_go      = idle_like && start && !abort;
   assign settle_tc     = (settle_cnt == CNT_TC);
   assign last_vec      = (vec_out == VEC_LAST);
   assign mismatch      = (dut_y != exp_y);
   assign count_err     = (state == S_SAMPLE) && !abort && mismatch;

   assign sample_strobe = (state == S_SAMPLE);
   assign busy          = (state == S_APPLY) || (state == S_SAMPLE);
   assign done          = (state == S_DONE);

   // error count including the current sample, saturating at all-ones
   always_comb begin
      err_after = err_count;
      if (count_err && (err_count != ERR_MAX)) begin
         err_after = err_count + ERR_W'(1);
      end
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (start_go) begin
               state_nxt = S_APPLY;
            end
         end
         S_APPLY: begin
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (settle_tc) begin
               state_nxt = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (last_vec && !mode_cont) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_APPLY;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // vector walk, settle timer and result accumulation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_cont        <= 1'b0;
         settle_cnt       <= '0;
         vec_out          <= '0;
         sweep_done       <= 1'b0;
         pass             <= 1'b0;
         err_count        <= '0;
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
         sweep_cnt        <= '0;
      end else begin
         sweep_done <= 1'b0;
         if (start_go) begin
            mode_cont        <= continuous;
            settle_cnt       <= '0;
            vec_out          <= '0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            sweep_cnt        <= '0;
         end else if ((state == S_APPLY) && !abort) begin
            settle_cnt <= settle_cnt + CNT_W'(1);
         end else if ((state == S_SAMPLE) && !abort) begin
            err_count  <= err_after;
            settle_cnt <= '0;
            if (count_err && !first_fail_valid) begin
               first_fail_valid <= 1'b1;
               first_fail_vec   <= vec_out;
            end
            // a finished single sweep keeps showing its last vector
            if (!last_vec || mode_cont) begin
               vec_out <= vec_out + N_IN'(1);
            end
            if (last_vec) begin
               sweep_done <= 1'b1;
               sweep_cnt  <= sweep_cnt + SWP_W'(1);
               pass       <= (err_after == '0);
            end
         end
      end
   end

endmodule

// File: tb/tb_exhaustive_vector_checker.sv
// Bench for exhaustive_vector_checker: instance A (SETTLE=1, ERR_W=16) and
// instance B (SETTLE=3, ERR_W=4) against a sweep-level reference model.
module tb_exhaustive_vector_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [1:0]  start, cont, abort;
   logic [15:0] exp_tab;
   logic [15:0] mask_a, mask_b;

   logic [3:0]  a_vec;   logic a_dut_y, a_exp_y, a_strobe, a_busy, a_done, a_swd, a_pass, a_ffv;
   logic [15:0] a_err;   logic [3:0] a_ffvec;  logic [7:0] a_swc;
   logic [3:0]  b_vec;   logic b_dut_y, b_exp_y, b_strobe, b_busy, b_done, b_swd, b_pass, b_ffv;
   logic [3:0]  b_err;   logic [3:0] b_ffvec;  logic [7:0] b_swc;

   // golden block is a lookup table; the faulty DUT flips the table where mask is set
   always_comb begin
      a_exp_y = exp_tab[a_vec];
      a_dut_y = exp_tab[a_vec] ^ mask_a[a_vec];
      b_exp_y = exp_tab[b_vec];
      b_dut_y = exp_tab[b_vec] ^ mask_b[b_vec];
   end

   exhaustive_vector_checker #(.N_IN(4), .N_OUT(1), .SETTLE(1), .ERR_W(16), .SWP_W(8)) u_dut_a (
      .clk(clk), .rst(rst), .start(start[0]), .continuous(cont[0]), .abort(abort[0]),
      .vec_out(a_vec), .dut_y(a_dut_y), .exp_y(a_exp_y), .sample_strobe(a_strobe),
      .busy(a_busy), .done(a_done), .sweep_done(a_swd), .pass(a_pass), .err_count(a_err),
      .first_fail_valid(a_ffv), .first_fail_vec(a_ffvec), .sweep_cnt(a_swc));

   exhaustive_vector_checker #(.N_IN(4), .N_OUT(1), .SETTLE(3), .ERR_W(4), .SWP_W(8)) u_dut_b (
      .clk(clk), .rst(rst), .start(start[1]), .continuous(cont[1]), .abort(abort[1]),
      .vec_out(b_vec), .dut_y(b_dut_y), .exp_y(b_exp_y), .sample_strobe(b_strobe),
      .busy(b_busy), .done(b_done), .sweep_done(b_swd), .pass(b_pass), .err_count(b_err),
      .first_fail_valid(b_ffv), .first_fail_vec(b_ffvec), .sweep_cnt(b_swc));

   int errors = 0;
   int checks = 0;

   logic [3:0]  o_vec, o_ffvec;
   logic [15:0] o_err;
   logic [7:0]  o_swc;
   logic        o_strobe, o_busy, o_done, o_swd, o_pass, o_ffv;

   task automatic snap(input int sel);
      if (sel == 0) begin
         o_vec = a_vec; o_strobe = a_strobe; o_busy = a_busy; o_done = a_done; o_swd = a_swd;
         o_pass = a_pass; o_err = a_err; o_ffv = a_ffv; o_ffvec = a_ffvec; o_swc = a_swc;
      end else begin
         o_vec = b_vec; o_strobe = b_strobe; o_busy = b_busy; o_done = b_done; o_swd = b_swd;
         o_pass = b_pass; o_err = {12'd0, b_err}; o_ffv = b_ffv; o_ffvec = b_ffvec; o_swc = b_swc;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input int sel);
      tick();
      start[sel] = 1'b1;
      tick();
      start[sel] = 1'b0;
   endtask

   // mismatches among the first n vectors of one sweep, clipped at the counter maximum
   function automatic int model_err(input logic [15:0] m, input int n, input int emax);
      int c = 0;
      for (int i = 0; i < n && i < 16; i++) if (m[i]) c++;
      return (c > emax) ? emax : c;
   endfunction

   task automatic run_single(input int sel, input logic [15:0] m);
      int per, total, emax, pop, first, exp_err;
      per   = (sel == 0) ? 2 : 4;
      total = 16 * per;
      emax  = (sel == 0) ? 65535 : 15;
      if (sel == 0) mask_a = m; else mask_b = m;
      pop = $countones(m);
      first = 0;
      for (int i = 15; i >= 0; i--) if (m[i]) first = i;
      exp_err = (pop > emax) ? emax : pop;
      cont[sel] = 1'b0;
      pulse_start(sel);
      for (int k = 0; k < total; k++) begin
         snap(sel);
         checks++;
         if (o_vec !== 4'(k / per) || o_busy !== 1'b1 || o_done !== 1'b0 || o_swd !== 1'b0 ||
             o_strobe !== (k % per == per - 1) || o_err !== 16'(model_err(m, k / per, emax))) begin
            errors++;
            $display("FAIL walk sel=%0d k=%0d: vec=%0d busy=%b done=%b swd=%b strobe=%b err=%0d, want vec=%0d err=%0d",
                     sel, k, o_vec, o_busy, o_done, o_swd, o_strobe, o_err, k / per, model_err(m, k / per, emax));
         end
         tick();
      end
      snap(sel);
      checks++;
      if (o_done !== 1'b1 || o_busy !== 1'b0 || o_swd !== 1'b1 || o_swc !== 8'd1) begin
         errors++;
         $display("FAIL sweep_end sel=%0d: done=%b busy=%b swd=%b swc=%0d, want 1 0 1 1", sel, o_done, o_busy, o_swd, o_swc);
      end
      checks++;
      if (o_err !== 16'(exp_err) || o_pass !== (exp_err == 0)) begin
         errors++;
         $display("FAIL result sel=%0d: err=%0d pass=%b, want err=%0d pass=%b", sel, o_err, o_pass, exp_err, exp_err == 0);
      end
      checks++;
      if (o_ffv !== (pop != 0) || (pop != 0 && o_ffvec !== 4'(first))) begin
         errors++;
         $display("FAIL first_fail sel=%0d: valid=%b vec=%0d, want valid=%b vec=%0d", sel, o_ffv, o_ffvec, pop != 0, first);
      end
      tick();
      snap(sel);
      checks++;
      if (o_swd !== 1'b0 || o_done !== 1'b1 || o_err !== 16'(exp_err)) begin
         errors++;
         $display("FAIL done_hold sel=%0d: swd=%b done=%b err=%0d, want 0 1 %0d", sel, o_swd, o_done, o_err, exp_err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      checks++;
      if ({a_vec, a_strobe, a_busy, a_done, a_swd, a_pass, a_err, a_ffv, a_ffvec, a_swc} !== '0) begin
         errors++;
         $display("FAIL reset_a: vec=%0d busy=%b done=%b err=%0d swc=%0d, want all 0", a_vec, a_busy, a_done, a_err, a_swc);
      end
      checks++;
      if ({b_vec, b_strobe, b_busy, b_done, b_swd, b_pass, b_err, b_ffv, b_ffvec, b_swc} !== '0) begin
         errors++;
         $display("FAIL reset_b: vec=%0d busy=%b done=%b err=%0d swc=%0d, want all 0", b_vec, b_busy, b_done, b_err, b_swc);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_sweeps();
      run_single(0, 16'h0000);
      run_single(0, 16'h0400);
      run_single(0, 16'hFFFF);
      run_single(1, 16'hFFFF);
      run_single(1, 16'h0000);
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         exp_tab = 16'($urandom);
         run_single(0, 16'($urandom) & 16'($urandom));
         run_single(1, 16'($urandom));
      end
   endtask

   task automatic test_continuous();
      mask_b = 16'hFFFF;
      cont[1] = 1'b1;
      pulse_start(1);
      cont[1] = 1'b0;
      for (int k = 0; k <= 192; k++) begin
         snap(1);
         checks++;
         if (o_err !== 16'((k / 4 > 15) ? 15 : k / 4) || o_swd !== (k > 0 && k % 64 == 0) ||
             o_swc !== 8'(k / 64) || o_busy !== 1'b1 || o_done !== 1'b0 || o_pass !== 1'b0 ||
             o_vec !== 4'((k / 4) % 16)) begin
            errors++;
            $display("FAIL continuous k=%0d: err=%0d swd=%b swc=%0d busy=%b done=%b pass=%b vec=%0d",
                     k, o_err, o_swd, o_swc, o_busy, o_done, o_pass, o_vec);
         end
         if (k < 192) tick();
      end
      abort[1] = 1'b1;
      tick();
      abort[1] = 1'b0;
      snap(1);
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_err !== 16'd15 || o_swc !== 8'd3 || o_ffvec !== 4'd0) begin
         errors++;
         $display("FAIL continuous_abort: busy=%b done=%b err=%0d swc=%0d ffvec=%0d, want 0 0 15 3 0",
                  o_busy, o_done, o_err, o_swc, o_ffvec);
      end
   endtask

   task automatic test_abort();
      mask_a = 16'h0000;
      pulse_start(0);
      for (int k = 0; k < 12; k++) tick();
      abort[0] = 1'b1;
      tick();
      abort[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         snap(0);
         checks++;
         if (o_busy !== 1'b0 || o_done !== 1'b0 || o_vec !== 4'd6 || o_strobe !== 1'b0 || o_swc !== 8'd0) begin
            errors++;
            $display("FAIL abort_apply c=%0d: busy=%b done=%b vec=%0d swc=%0d, want 0 0 6 0", k, o_busy, o_done, o_vec, o_swc);
         end
         tick();
      end
      mask_a = 16'hFFFF;
      pulse_start(0);
      for (int k = 0; k < 7; k++) tick();
      abort[0] = 1'b1;
      tick();
      abort[0] = 1'b0;
      snap(0);
      checks++;
      if (o_err !== 16'd3 || o_ffv !== 1'b1 || o_ffvec !== 4'd0 || o_vec !== 4'd3 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_sample: err=%0d ffv=%b ffvec=%0d vec=%0d busy=%b, want 3 1 0 3 0", o_err, o_ffv, o_ffvec, o_vec, o_busy);
      end
      start[0] = 1'b1;
      abort[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      abort[0] = 1'b0;
      tick();
      snap(0);
      checks++;
      if (o_busy !== 1'b0 || o_err !== 16'd3 || o_vec !== 4'd3) begin
         errors++;
         $display("FAIL start_abort_idle: busy=%b err=%0d vec=%0d, want 0 3 3", o_busy, o_err, o_vec);
      end
      run_single(0, 16'h0000);
   endtask

   task automatic test_reset_mid();
      mask_a = 16'h0400;
      pulse_start(0);
      for (int k = 0; k < 18; k++) tick();
      start[0] = 1'b1;
      for (int k = 18; k < 22; k++) begin
         snap(0);
         checks++;
         if (o_vec !== 4'(k / 2) || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_start k=%0d: vec=%0d busy=%b, want %0d 1", k, o_vec, o_busy, k / 2);
         end
         tick();
      end
      start[0] = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({a_vec, a_strobe, a_busy, a_done, a_swd, a_pass, a_err, a_ffv, a_ffvec, a_swc} !== '0) begin
         errors++;
         $display("FAIL reset_mid: vec=%0d busy=%b err=%0d swc=%0d, want all 0", a_vec, a_busy, a_err, a_swc);
      end
      tick();
      tick();
      @(negedge clk);
      rst = 1'b0;
      tick();
      checks++;
      if (a_busy !== 1'b0 || a_vec !== 4'd0 || a_done !== 1'b0) begin
         errors++;
         $display("FAIL after_reset: busy=%b vec=%0d done=%b, want 0 0 0", a_busy, a_vec, a_done);
      end
   endtask

   initial begin
      start = '0; cont = '0; abort = '0;
      mask_a = '0; mask_b = '0;
      exp_tab = 16'hA5C3;
      test_reset();
      test_sweeps();
      test_random();
      test_continuous();
      test_abort();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
